// File: rtl/accel_bcd_encoder.sv
// accel_bcd_encoder: signed accelerometer sample -> sign-magnitude BCD for a
// 4-position 7-segment display, plus the digit-scan index for the display driver.
//
// Conversion is an iterative shift-add-3 (double-dabble) over DATA_W cycles behind a
// valid/ready handshake. The committed digits hold steady between conversions.
//
// Optional build macro: ACCEL_LEAD_BLANK_EN (leading-zero blank mask on 'blank').
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   sample            signed two's-complement sample (DATA_W bits)
//   sample_valid      qualifies sample, accepted when ready=1
//   ready             high while idle and able to accept a sample
//   done              one-cycle pulse when new digits are committed
//   sign              committed value is negative
//   thousands..ones   committed BCD digits
//   ovf               committed magnitude exceeded 9999 (digits forced to 9999)
//   Array             digit-scan index, 0 = sign position .. 3 = ones
//   blank             leading-zero blank mask, bit3 = thousands .. bit0 = ones
module accel_bcd_encoder #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              ready,
    output logic              done,
    output logic              sign,
    output logic [3:0]        thousands,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones,
    output logic              ovf,
    output logic [1:0]        Array,
    output logic [3:0]        blank
);

    localparam int unsigned BCD_W = 20;
    localparam int unsigned IT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state;
    logic              sign_r;
    logic [DATA_W-1:0] mag;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  scratch_adj;
    logic [IT_W-1:0]   it_cnt;
    logic              commit_ovf;
    logic              commit_zero;
    logic [CNT_W-1:0]  presc;

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Ten-thousands nibble nonzero means the magnitude does not fit four digits;
    // an all-zero scratch at commit means the magnitude was zero.
    assign commit_ovf  = |scratch[BCD_W-1:16];
    assign commit_zero = (scratch == '0);

    // Conversion FSM with registered handshake and display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            sign      <= 1'b0;
            thousands <= 4'd0;
            hundreds  <= 4'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            ovf       <= 1'b0;
            sign_r    <= 1'b0;
            mag       <= '0;
            scratch   <= '0;
            it_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid && ready) begin
                        sign_r  <= sample[DATA_W-1];
                        // Most negative input negates to 2^(DATA_W-1), still representable unsigned.
                        mag     <= sample[DATA_W-1] ? DATA_W'(~sample + DATA_W'(1)) : sample;
                        scratch <= '0;
                        it_cnt  <= '0;
                        ready   <= 1'b0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    {scratch, mag} <= {scratch_adj[BCD_W-2:0], mag, 1'b0};
                    it_cnt         <= it_cnt + IT_W'(1);
                    if (it_cnt == IT_W'(DATA_W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    ovf  <= commit_ovf;
                    sign <= sign_r & ~commit_zero;
                    if (commit_ovf) begin
                        thousands <= 4'd9;
                        hundreds  <= 4'd9;
                        tens      <= 4'd9;
                        ones      <= 4'd9;
                    end else begin
                        thousands <= scratch[15:12];
                        hundreds  <= scratch[11:8];
                        tens      <= scratch[7:4];
                        ones      <= scratch[3:0];
                    end
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running scan prescaler; Array steps once per prescaler wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            Array <= 2'd0;
        end else if (presc == CNT_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            Array <= Array + 2'd1;
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

`ifdef ACCEL_LEAD_BLANK_EN
    logic lz3;
    logic lz2;
    logic lz1;

    // Leading-zero chain over the digits about to be committed; ones never blanks.
    always_comb begin
        lz3 = (scratch[15:12] == 4'd0);
        lz2 = lz3 & (scratch[11:8] == 4'd0);
        lz1 = lz2 & (scratch[7:4] == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank <= 4'b0000;
        end else if (state == COMMIT) begin
            blank <= commit_ovf ? 4'b0000 : {lz3, lz2, lz1, 1'b0};
        end
    end
`else
    assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_accel_bcd_encoder.sv
// Self-checking bench for accel_bcd_encoder: a 12-bit instance (REFRESH_DIV=4) carries
// the table, random, reset, handshake and scan checks; a 16-bit instance covers overflow.
module tb_accel_bcd_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [11:0] a_sample;
    logic        a_valid, a_ready, a_done, a_sign, a_ovf;
    logic [3:0]  a_th, a_hu, a_te, a_on, a_blank;
    logic [1:0]  a_arr;

    logic [15:0] b_sample;
    logic        b_valid, b_ready, b_done, b_sign, b_ovf;
    logic [3:0]  b_th, b_hu, b_te, b_on, b_blank;
    logic [1:0]  b_arr;

    accel_bcd_encoder #(.DATA_W(12), .REFRESH_DIV(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .sample(a_sample), .sample_valid(a_valid),
        .ready(a_ready), .done(a_done), .sign(a_sign), .thousands(a_th),
        .hundreds(a_hu), .tens(a_te), .ones(a_on), .ovf(a_ovf),
        .Array(a_arr), .blank(a_blank)
    );

    accel_bcd_encoder #(.DATA_W(16), .REFRESH_DIV(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .sample(b_sample), .sample_valid(b_valid),
        .ready(b_ready), .done(b_done), .sign(b_sign), .thousands(b_th),
        .hundreds(b_hu), .tens(b_te), .ones(b_on), .ovf(b_ovf),
        .Array(b_arr), .blank(b_blank)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: decimal digits of |v| by plain arithmetic, saturating above 9999.
    task automatic model(input int v, output int s, output int th, output int hu,
                         output int te, output int on, output int ov, output int bl);
        int m;
        m  = (v < 0) ? -v : v;
        s  = (v < 0) ? 1 : 0;
        ov = (m > 9999) ? 1 : 0;
        if (ov == 1) m = 9999;
        th = (m / 1000) % 10;
        hu = (m / 100) % 10;
        te = (m / 10) % 10;
        on = m % 10;
        bl = 0;
`ifdef ACCEL_LEAD_BLANK_EN
        if (ov == 0) begin
            if (th == 0) bl += 8;
            if (th == 0 && hu == 0) bl += 4;
            if (th == 0 && hu == 0 && te == 0) bl += 2;
        end
`endif
    endtask

    task automatic check_a(input string tag, input int v);
        int s, th, hu, te, on, ov, bl;
        model(v, s, th, hu, te, on, ov, bl);
        chk({tag, " sign"}, 32'(a_sign), 32'(s));
        chk({tag, " digits"}, {16'd0, a_th, a_hu, a_te, a_on},
            32'((th << 12) | (hu << 8) | (te << 4) | on));
        chk({tag, " ovf"}, 32'(a_ovf), 32'(ov));
        chk({tag, " blank"}, 32'(a_blank), 32'(bl));
    endtask

    task automatic check_b(input string tag, input int v);
        int s, th, hu, te, on, ov, bl;
        model(v, s, th, hu, te, on, ov, bl);
        chk({tag, " sign"}, 32'(b_sign), 32'(s));
        chk({tag, " digits"}, {16'd0, b_th, b_hu, b_te, b_on},
            32'((th << 12) | (hu << 8) | (te << 4) | on));
        chk({tag, " ovf"}, 32'(b_ovf), 32'(ov));
        chk({tag, " blank"}, 32'(b_blank), 32'(bl));
    endtask

    // One handshake on instance A; lat = edges after the handshake edge until done is seen.
    task automatic run_a(input logic [11:0] s, output int lat);
        int k;
        k = 0;
        while (!a_ready && k < 50) begin @(posedge clk); #1; k++; end
        a_sample = s;
        a_valid  = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (a_done) lat = i;
        end
    endtask

    task automatic run_b(input logic [15:0] s, output int lat);
        int k;
        k = 0;
        while (!b_ready && k < 50) begin @(posedge clk); #1; k++; end
        b_sample = s;
        b_valid  = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (b_done) lat = i;
        end
    endtask

    typedef struct {
        logic [11:0] s;
        int          sg, th, hu, te, on, ov;
        logic [3:0]  bl;   // mask expected when leading-zero blanking is built in
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, cnt, t1, t2, v;
        logic [3:0] exp_bl;

        vecs[0] = '{12'h4D2, 0, 1, 2, 3, 4, 0, 4'b0000};
        vecs[1] = '{12'h800, 1, 2, 0, 4, 8, 0, 4'b0000};
        vecs[2] = '{12'hFFF, 1, 0, 0, 0, 1, 0, 4'b1110};
        vecs[3] = '{12'h000, 0, 0, 0, 0, 0, 0, 4'b1110};
        vecs[4] = '{12'h7FF, 0, 2, 0, 4, 7, 0, 4'b0000};
        vecs[5] = '{12'h801, 1, 2, 0, 4, 7, 0, 4'b0000};
        vecs[6] = '{12'h00A, 0, 0, 0, 1, 0, 0, 4'b1100};
        vecs[7] = '{12'hF9C, 1, 0, 1, 0, 0, 0, 4'b1000};

        rst = 1'b1;
        a_sample = '0; a_valid = 1'b0;
        b_sample = '0; b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(a_ready), 32'd1);
        chk("reset done", 32'(a_done), 32'd0);
        chk("reset digits", {16'd0, a_th, a_hu, a_te, a_on}, 32'd0);
        chk("reset sign/ovf", {30'd0, a_sign, a_ovf}, 32'd0);
        chk("reset blank", 32'(a_blank), 32'd0);
        chk("reset Array", 32'(a_arr), 32'd0);
        rst = 1'b0;

        // Directed table on the 12-bit instance.
        for (int i = 0; i < 8; i++) begin
            run_a(vecs[i].s, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd13);
            chk($sformatf("vec%0d sign", i), 32'(a_sign), 32'(vecs[i].sg));
            chk($sformatf("vec%0d digits", i), {16'd0, a_th, a_hu, a_te, a_on},
                32'((vecs[i].th << 12) | (vecs[i].hu << 8) | (vecs[i].te << 4) | vecs[i].on));
            chk($sformatf("vec%0d ovf", i), 32'(a_ovf), 32'(vecs[i].ov));
`ifdef ACCEL_LEAD_BLANK_EN
            exp_bl = vecs[i].bl;
`else
            exp_bl = 4'b0000;
`endif
            chk($sformatf("vec%0d blank", i), 32'(a_blank), 32'(exp_bl));
        end

        // Random samples against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            a_sample = 12'($urandom);
            v = int'($signed(a_sample));
            run_a(a_sample, lat);
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'd13);
            check_a($sformatf("rnd%0d(%0d)", i, v), v);
        end

        // 16-bit instance: overflow saturation, recovery, most negative, random.
        run_b(16'h7FFF, lat);
        chk("b 7FFF latency", 32'(lat), 32'd17);
        check_b("b 7FFF", 32767);
        run_b(16'h0000, lat);
        check_b("b zero", 0);
        run_b(16'h8000, lat);
        check_b("b 8000", -32768);
        for (int i = 0; i < 10; i++) begin
            b_sample = 16'($urandom);
            v = int'($signed(b_sample));
            run_b(b_sample, lat);
            check_b($sformatf("b rnd%0d(%0d)", i, v), v);
        end

        // Reset two cycles mid-conversion: nothing committed, no late done.
        run_a(12'h4D2, lat);
        a_sample = 12'h123; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        chk("abort ready", 32'(a_ready), 32'd1);
        chk("abort done", 32'(a_done), 32'd0);
        chk("abort digits", {16'd0, a_th, a_hu, a_te, a_on}, 32'd0);
        chk("abort sign", 32'(a_sign), 32'd0);
        chk("abort Array", 32'(a_arr), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (a_done) cnt++;
        end
        chk("abort no late done", 32'(cnt), 32'd0);

        // A single valid pulse during conversion is dropped.
        a_sample = 12'd321; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin a_sample = 12'd999; a_valid = 1'b1; end
            else if (i == 4) a_valid = 1'b0;
            if (a_done) cnt++;
        end
        chk("busy pulse done count", 32'(cnt), 32'd1);
        check_a("busy pulse result", 321);

        // Valid held through commit is taken on the first idle cycle.
        a_sample = 12'd55; a_valid = 1'b1;
        @(posedge clk); #1;
        a_sample = 12'hF00;
        t1 = -1; t2 = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (t1 >= 0 && i == t1 + 1) a_valid = 1'b0;
            if (a_done) begin
                if (t1 < 0) begin
                    t1 = i;
                    chk("b2b first digits", {16'd0, a_th, a_hu, a_te, a_on}, 32'h0055);
                end else if (t2 < 0) begin
                    t2 = i;
                end
            end
        end
        a_valid = 1'b0;
        chk("b2b first latency", 32'(t1), 32'd13);
        chk("b2b done spacing", 32'(t2 - t1), 32'd14);
        check_a("b2b second", -256);

        // Scan index steps every 4 clocks from reset, regardless of a conversion in flight.
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_sample = 12'd77; a_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) a_valid = 1'b0;
            chk($sformatf("scan k=%0d", k), 32'(a_arr), 32'((k / 4) % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
